// File: rtl/pcpu_cache_pkg.sv
// Shared types and helpers for the pcpu data cache: FSM state encoding,
// address field extraction for a given geometry, and a saturating counter step.
package pcpu_cache_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REFILL = 3'd1,
        RESP   = 3'd2,
        WRITE  = 3'd3,
        BYPASS = 3'd4
    } state_e;

    // Word offset within a line; callers truncate to $clog2(words) bits.
    function automatic logic [31:0] addr_off(input logic [31:0] addr, input int words);
        return addr & 32'(words - 1);
    endfunction

    // Line index; callers truncate to $clog2(lines) bits.
    function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int lines,
                                             input int words);
        return (addr >> $clog2(words)) & 32'(lines - 1);
    endfunction

    // Tag is everything above offset and index.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int lines,
                                             input int words);
        return addr >> ($clog2(words) + $clog2(lines));
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pcpu_dcache_tagram.sv
// Tag and valid store for the direct-mapped cache. One combinational read
// port, one synchronous write/invalidate port, and a whole-array valid clear.
module pcpu_dcache_tagram #(
    parameter int LINES = 8,
    parameter int TW    = 9,
    localparam int IW   = $clog2(LINES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_all,
    input  logic [IW-1:0] rd_idx,
    output logic [TW-1:0] rd_tag,
    output logic          rd_valid,
    input  logic          wr_en,
    input  logic          inv_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [TW-1:0] wr_tag
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TW-1:0]    tag_q [LINES];
    logic [TW-1:0]    tag_d [LINES];

    assign rd_tag   = tag_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];

    // Next valid/tag contents; a clear wins over a concurrent line update.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (clear_all) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
        end else if (inv_en) begin
            valid_d[wr_idx] = 1'b0;
        end
    end

    // Valid bits reset to empty; tags need no reset since valid gates them.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
        tag_q <= tag_d;
    end

endmodule

// File: rtl/pcpu_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with burst line
// refill, bypass mode, deferred flush and saturating hit/miss counters.
//
//   state  | meaning
//   IDLE   | accept requests; read hits complete here with zero wait states
//   REFILL | burst-read WORDS words of the missed line from memory
//   RESP   | return the requested word of the freshly filled line
//   WRITE  | write-through to memory; update the line on a hit
//   BYPASS | uncached read straight from memory
module pcpu_dcache
    import pcpu_cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LINES  = 8,
    parameter int WORDS  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = ADDR_W - OW - IW;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              en_q, en_d;
    logic [OW-1:0]     cnt_q, cnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [15:0]       hit_cnt_q, hit_cnt_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;

    logic [DATA_W-1:0] data_q [LINES*WORDS];

    logic [ADDR_W-1:0] lk_addr;
    logic [OW-1:0]     lk_off;
    logic [IW-1:0]     lk_idx;
    logic [TW-1:0]     lk_tag;
    logic [TW-1:0]     rd_tag;
    logic              rd_valid;
    logic              lk_hit;
    logic [OW-1:0]     cnt_nxt;

    logic              ready_c;
    logic [DATA_W-1:0] rdata_c;
    logic              clear_all;
    logic              tag_wr;
    logic              tag_inv;
    logic              data_we;
    logic [IW+OW-1:0]  data_wa;
    logic [DATA_W-1:0] data_wd;

    // In IDLE the lookup follows the live request; afterwards the latched one.
    assign lk_addr = (state_q == IDLE) ? cpu_addr : addr_q;
    assign lk_off  = OW'(addr_off(32'(lk_addr), WORDS));
    assign lk_idx  = IW'(addr_idx(32'(lk_addr), LINES, WORDS));
    assign lk_tag  = TW'(addr_tag(32'(lk_addr), LINES, WORDS));
    assign lk_hit  = rd_valid && (rd_tag == lk_tag);
    assign cnt_nxt = cnt_q + OW'(1);

    pcpu_dcache_tagram #(
        .LINES (LINES),
        .TW    (TW)
    ) u_tagram (
        .clock     (clock),
        .reset     (reset),
        .clear_all (clear_all),
        .rd_idx    (lk_idx),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .wr_en     (tag_wr),
        .inv_en    (tag_inv),
        .wr_idx    (lk_idx),
        .wr_tag    (lk_tag)
    );

    // Next-state, registered memory-side outputs and combinational CPU response.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        en_d         = en_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q | flush;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        ready_c      = 1'b0;
        rdata_c      = '0;
        clear_all    = 1'b0;
        tag_wr       = 1'b0;
        tag_inv      = 1'b0;
        data_we      = 1'b0;
        data_wa      = {lk_idx, lk_off};
        data_wd      = '0;
        case (state_q)
            IDLE: begin
                if (flush || flush_pend_q) begin
                    clear_all    = 1'b1;
                    flush_pend_d = 1'b0;
                end else if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    en_d    = enable;
                    if (cpu_we) begin
                        state_d     = WRITE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                    end else if (!enable) begin
                        state_d    = BYPASS;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = cpu_addr;
                    end else if (lk_hit) begin
                        ready_c   = 1'b1;
                        rdata_c   = data_q[{lk_idx, lk_off}];
                        hit_cnt_d = sat_inc(hit_cnt_q);
                    end else begin
                        state_d    = REFILL;
                        cnt_d      = '0;
                        miss_cnt_d = sat_inc(miss_cnt_q);
                        tag_inv    = 1'b1;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {lk_tag, lk_idx, {OW{1'b0}}};
                    end
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    data_we = 1'b1;
                    data_wa = {lk_idx, cnt_q};
                    data_wd = mem_rdata;
                    if (cnt_q == OW'(WORDS - 1)) begin
                        tag_wr    = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = RESP;
                    end else begin
                        cnt_d      = cnt_nxt;
                        mem_addr_d = {lk_tag, lk_idx, cnt_nxt};
                    end
                end
            end
            RESP: begin
                ready_c = 1'b1;
                rdata_c = data_q[{lk_idx, lk_off}];
                state_d = IDLE;
            end
            WRITE: begin
                if (mem_ack) begin
                    ready_c   = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                    if (en_q && lk_hit) begin
                        data_we = 1'b1;
                        data_wd = wdata_q;
                    end
                end
            end
            BYPASS: begin
                if (mem_ack) begin
                    ready_c   = 1'b1;
                    rdata_c   = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and memory-interface registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            en_q         <= 1'b0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            en_q         <= en_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Data array; its contents only matter once the matching valid bit is set.
    always_ff @(posedge clock) begin
        if (!reset && data_we) begin
            data_q[data_wa] <= data_wd;
        end
    end

    // A reset cycle never reports a completed access.
    assign cpu_ready = ready_c & ~reset;
    assign cpu_rdata = reset ? '0 : rdata_c;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_pcpu_dcache.sv
// Directed bench for pcpu_dcache with a memory that acks one cycle after each
// request and returns 0xA000 | addr.
module tb_pcpu_dcache;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        flush;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_cnt  = 0;
    int          wr_cnt   = 0;
    logic [15:0] last_wr_addr;
    logic [15:0] last_wr_data;
    logic [15:0] rd_log [$];

    pcpu_dcache dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .flush     (flush),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory responder: ack the cycle after a request is seen, then one idle cycle.
    always @(posedge clock) begin
        if (reset) begin
            mem_ack   <= 1'b0;
            mem_rdata <= 16'h0000;
        end else begin
            mem_ack   <= mem_req && !mem_ack;
            mem_rdata <= 16'hA000 | mem_addr;
            if (mem_req && mem_ack) begin
                ack_cnt <= ack_cnt + 1;
                if (mem_we) begin
                    wr_cnt       <= wr_cnt + 1;
                    last_wr_addr <= mem_addr;
                    last_wr_data <= mem_wdata;
                end else begin
                    rd_log.push_back(mem_addr);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                             output logic [15:0] rd, output int cycles);
        @(negedge clock);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cycles    = 0;
        rd        = 16'h0000;
        #1;
        while (!cpu_ready && cycles < 60) begin
            @(negedge clock);
            #1;
            cycles++;
        end
        check("access_done", 32'(cpu_ready), 32'd1);
        if (cpu_ready) rd = cpu_rdata;
        @(negedge clock);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    task automatic check_refill(input string tag, input logic [15:0] base);
        check({tag, "_nreads"}, 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
            check({tag, "_addr"}, 32'(rd_log[i]), 32'(base + 16'(i)));
        end
    endtask

    initial begin
        logic [15:0] rd;
        int          cyc;
        int          base;
        int          t;

        reset     = 1'b1;
        enable    = 1'b1;
        flush     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 16'h0000;
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(cpu_ready), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_hit", 32'(hit_cnt), 32'd0);
        check("rst_miss", 32'(miss_cnt), 32'd0);
        reset = 1'b0;

        // 1: cold miss with burst refill, then a zero-wait hit
        rd_log.delete();
        do_access(1'b0, 16'h0012, 16'h0, rd, cyc);
        check("t1_rdata", 32'(rd), 32'hA012);
        check("t1_latency", 32'(cyc), 32'd9);
        check("t1_miss", 32'(miss_cnt), 32'd1);
        check("t1_hit", 32'(hit_cnt), 32'd0);
        check_refill("t1_refill", 16'h0010);
        do_access(1'b0, 16'h0013, 16'h0, rd, cyc);
        check("t1_hit_rdata", 32'(rd), 32'hA013);
        check("t1_hit_latency", 32'(cyc), 32'd0);
        check("t1_hit_cnt", 32'(hit_cnt), 32'd1);

        // 2: write hit updates line; write miss does not allocate
        do_access(1'b1, 16'h0011, 16'h5555, rd, cyc);
        check("t2_wr_cnt", 32'(wr_cnt), 32'd1);
        check("t2_wr_addr", 32'(last_wr_addr), 32'h0011);
        check("t2_wr_data", 32'(last_wr_data), 32'h5555);
        check("t2_wr_latency", 32'(cyc), 32'd2);
        do_access(1'b0, 16'h0011, 16'h0, rd, cyc);
        check("t2_rd_hit_data", 32'(rd), 32'h5555);
        check("t2_rd_hit_lat", 32'(cyc), 32'd0);
        check("t2_hit_cnt", 32'(hit_cnt), 32'd2);
        do_access(1'b1, 16'h0100, 16'h1234, rd, cyc);
        check("t2_wr2_addr", 32'(last_wr_addr), 32'h0100);
        check("t2_wr2_data", 32'(last_wr_data), 32'h1234);
        check("t2_wr_no_cnt", 32'(miss_cnt), 32'd1);
        rd_log.delete();
        do_access(1'b0, 16'h0100, 16'h0, rd, cyc);
        check("t2_noalloc_rdata", 32'(rd), 32'hA100);
        check("t2_noalloc_miss", 32'(miss_cnt), 32'd2);
        check_refill("t2_refill", 16'h0100);

        // 3: conflict on index 4 between tags 0 and 1
        do_access(1'b0, 16'h0012, 16'h0, rd, cyc);
        check("t3_hit_rdata", 32'(rd), 32'hA012);
        check("t3_hit_cnt", 32'(hit_cnt), 32'd3);
        rd_log.delete();
        do_access(1'b0, 16'h0032, 16'h0, rd, cyc);
        check("t3_conf_rdata", 32'(rd), 32'hA032);
        check("t3_conf_miss", 32'(miss_cnt), 32'd3);
        check_refill("t3_refill", 16'h0030);
        do_access(1'b0, 16'h0012, 16'h0, rd, cyc);
        check("t3_reread_rdata", 32'(rd), 32'hA012);
        check("t3_reread_lat", 32'(cyc), 32'd9);
        check("t3_reread_miss", 32'(miss_cnt), 32'd4);

        // 4: flush in IDLE, then flush during the second refill word
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        fork
            do_access(1'b0, 16'h0012, 16'h0, rd, cyc);
            begin
                t = 0;
                while (!(mem_req && mem_addr == 16'h0011) && t < 40) begin
                    @(negedge clock);
                    t++;
                end
                check("t4_saw_word1", 32'(mem_addr), 32'h0011);
                flush = 1'b1;
                @(negedge clock);
                flush = 1'b0;
            end
        join
        check("t4_rdata", 32'(rd), 32'hA012);
        check("t4_miss", 32'(miss_cnt), 32'd5);
        do_access(1'b0, 16'h0013, 16'h0, rd, cyc);
        check("t4_after_flush_rdata", 32'(rd), 32'hA013);
        check("t4_after_flush_lat", 32'(cyc), 32'd9);
        check("t4_after_flush_miss", 32'(miss_cnt), 32'd6);

        // 5: bypass read leaves counters and cached line alone
        enable = 1'b0;
        rd_log.delete();
        do_access(1'b0, 16'h0012, 16'h0, rd, cyc);
        check("t5_byp_rdata", 32'(rd), 32'hA012);
        check("t5_byp_lat", 32'(cyc), 32'd2);
        check("t5_byp_nreads", 32'(rd_log.size()), 32'd1);
        check("t5_byp_hit", 32'(hit_cnt), 32'd3);
        check("t5_byp_miss", 32'(miss_cnt), 32'd6);
        enable = 1'b1;
        do_access(1'b0, 16'h0012, 16'h0, rd, cyc);
        check("t5_hit_rdata", 32'(rd), 32'hA012);
        check("t5_hit_lat", 32'(cyc), 32'd0);
        check("t5_hit_cnt", 32'(hit_cnt), 32'd4);

        // 6: reset partway through a refill
        @(negedge clock);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0052;
        base     = ack_cnt;
        t        = 0;
        while (ack_cnt < base + 2 && t < 40) begin
            @(negedge clock);
            t++;
        end
        check("t6_acks_before_rst", 32'(ack_cnt - base), 32'd2);
        check("t6_req_before_rst", 32'(mem_req), 32'd1);
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        check("t6_no_ready", 32'(cpu_ready), 32'd0);
        @(negedge clock);
        check("t6_mem_req_drop", 32'(mem_req), 32'd0);
        check("t6_hit_zero", 32'(hit_cnt), 32'd0);
        check("t6_miss_zero", 32'(miss_cnt), 32'd0);
        reset = 1'b0;
        rd_log.delete();
        do_access(1'b0, 16'h0012, 16'h0, rd, cyc);
        check("t6_rdata", 32'(rd), 32'hA012);
        check("t6_lat", 32'(cyc), 32'd9);
        check("t6_miss", 32'(miss_cnt), 32'd1);
        check_refill("t6_refill", 16'h0010);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
